multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RISC-V core: sequences the shared ALU, unified memory port
// and register file. Define MC_ILLEGAL_TRAP_EN to lock into a TRAP state on unsupported opcodes.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic       Illegal
);

  localparam int unsigned CntW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
`ifdef MC_ILLEGAL_TRAP_EN
    StBeq      = 4'd10,
    StTrap     = 4'd11
`else
    StBeq      = 4'd10
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wait_done;
  logic            pc_update;
  logic            branch;
  logic            ir_write_raw;
  logic            mem_write_raw;
  logic            reg_write_raw;

  // With no wait cycles the counter value is irrelevant and every wait state lasts one cycle.
  assign wait_done = (MEM_WAIT == 0) || (32'(cnt_q) == MEM_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (wait_done) state_d = StDecode;
      StDecode: begin
        unique case (Op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpJal:           state_d = StJal;
          OpBeq:           state_d = StBeq;
`ifdef MC_ILLEGAL_TRAP_EN
          default:         state_d = StTrap;
`else
          default:         state_d = StFetch;
`endif
        endcase
      end
      StMemAdr:   state_d = Op[5] ? StMemWrite : StMemRead;
      StMemRead:  if (wait_done) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StJal:      state_d = StAluWb;
      StBeq:      state_d = StFetch;
`ifdef MC_ILLEGAL_TRAP_EN
      StTrap:     state_d = StTrap;
`endif
      default:    state_d = StFetch;
    endcase
  end

  // Counter restarts on every entry to a wait state and only runs while the state is held.
  always_comb begin
    if ((state_q == StFetch || state_q == StMemRead) && state_d == state_q) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    unique case (state_q)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (wait_done) begin
          ir_write_raw = 1'b1;
          pc_update    = 1'b1;
        end
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      StMemWrite: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      StExecuteR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      StAluWb: reg_write_raw = 1'b1;
      StJal: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      StBeq: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (Op)
      OpStore: ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write enables are gated so a reset cycle can never commit state anywhere.
  assign PCWrite  = (pc_update | (branch & Zero)) & ~rst;
  assign IRWrite  = ir_write_raw & ~rst;
  assign MemWrite = mem_write_raw & ~rst;
  assign RegWrite = reg_write_raw & ~rst;

`ifdef MC_ILLEGAL_TRAP_EN
  assign Illegal = (state_q == StTrap);
`else
  assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: two instances (MEM_WAIT 0 and 3) checked cycle by
// cycle against per-instruction expected output sequences built from the instruction class.
module tb_multicycle_controller;

  localparam int unsigned MwA = 0;
  localparam int unsigned MwB = 3;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpBeq = 7'b1100011;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aluop;
    logic       rw;
    logic [1:0] imm;
    logic       ill;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [6:0] op;
  logic       zero;

  logic       pcw_a, adr_a, mw_a, irw_a, rw_a, ill_a;
  logic [1:0] res_a, sa_a, sb_a, aluop_a, imm_a;
  logic       pcw_b, adr_b, mw_b, irw_b, rw_b, ill_b;
  logic [1:0] res_b, sa_b, sb_b, aluop_b, imm_b;

  obs_t obs_a, obs_b;
  assign obs_a = {pcw_a, adr_a, mw_a, irw_a, res_a, sa_a, sb_a, aluop_a, rw_a, imm_a, ill_a};
  assign obs_b = {pcw_b, adr_b, mw_b, irw_b, res_b, sa_b, sb_b, aluop_b, rw_b, imm_b, ill_b};

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT(MwA)) u_dut_a (
    .clk(clk), .rst(rst_a), .Op(op), .Zero(zero),
    .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(mw_a), .IRWrite(irw_a),
    .ResultSrc(res_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ALUOp(aluop_a),
    .RegWrite(rw_a), .ImmSrc(imm_a), .Illegal(ill_a)
  );

  multicycle_controller #(.MEM_WAIT(MwB)) u_dut_b (
    .clk(clk), .rst(rst_b), .Op(op), .Zero(zero),
    .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .IRWrite(irw_b),
    .ResultSrc(res_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ALUOp(aluop_b),
    .RegWrite(rw_b), .ImmSrc(imm_b), .Illegal(ill_b)
  );

  int   checks = 0;
  int   failures = 0;
  int   sel = 0;
  int   zmode = 0;  // 0 random, 1 force Zero=1, 2 force Zero=0
  obs_t q_exp[$];
  bit   q_beq[$];

  function automatic obs_t cur();
    return (sel == 0) ? obs_a : obs_b;
  endfunction

  function automatic int unsigned cur_mw();
    return (sel == 0) ? MwA : MwB;
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o == OpLw || o == OpSw || o == OpR || o == OpI || o == OpJal || o == OpBeq;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OpSw) return 2'b01;
    if (o == OpBeq) return 2'b10;
    if (o == OpJal) return 2'b11;
    return 2'b00;
  endfunction

  function automatic obs_t mk(input logic pcw, input logic adr, input logic mw, input logic irw,
                              input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] aluop, input logic rw, input logic ill);
    obs_t v;
    v = {pcw, adr, mw, irw, res, sa, sb, aluop, rw, 2'b00, ill};
    return v;
  endfunction

  task automatic push(input obs_t v, input bit b);
    q_exp.push_back(v);
    q_beq.push_back(b);
  endtask

  // Expected cycle-by-cycle outputs for one whole instruction.
  task automatic build(input logic [6:0] o, input int unsigned mw);
    q_exp.delete();
    q_beq.delete();
    for (int i = 0; i <= int'(mw); i++) begin
      push(mk(i == int'(mw), 1'b0, 1'b0, i == int'(mw), 2'd2, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0), 1'b0);
    end
    push(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0), 1'b0);
    if (o == OpLw || o == OpSw) begin
      push(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0), 1'b0);
      if (o == OpLw) begin
        for (int i = 0; i <= int'(mw); i++) begin
          push(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), 1'b0);
        end
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0), 1'b0);
      end else begin
        push(mk(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), 1'b0);
      end
    end else if (o == OpR || o == OpI || o == OpJal) begin
      if (o == OpR) push(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0), 1'b0);
      if (o == OpI) push(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd2, 1'b0, 1'b0), 1'b0);
      if (o == OpJal) push(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0), 1'b0);
      push(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0), 1'b0);
    end else if (o == OpBeq) begin
      push(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0), 1'b1);
    end else begin
`ifdef MC_ILLEGAL_TRAP_EN
      for (int i = 0; i < 4; i++) begin
        push(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1), 1'b0);
      end
`endif
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input string tag, input obs_t e, input bit b);
    obs_t got;
    zero = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom);
    @(negedge clk);
    e.imm = imm_of(op);
    if (b) e.pcw = zero;
    got = cur();
    checks++;
    assert (got === e) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_enables_off(input string tag);
    obs_t got;
    @(negedge clk);
    got = cur();
    checks++;
    assert ({got.pcw, got.mw, got.irw, got.rw} === 4'b0000) else begin
      failures++;
      $error("FAIL %s enables got=%b exp=0000", tag, {got.pcw, got.mw, got.irw, got.rw});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int s);
    sel = s;
    rst_a = 1'b1;
    rst_b = 1'b1;
    check_enables_off("reset");
    rst_a = (s != 0);
    rst_b = (s != 1);
  endtask

  task automatic run_instr(input string name, input logic [6:0] o, input int abort_at);
    op = o;
    build(o, cur_mw());
    for (int i = 0; i < q_exp.size(); i++) begin
      if (i == abort_at) begin
        apply_reset(sel);
        return;
      end
      step($sformatf("%s_c%0d", name, i), q_exp[i], q_beq[i]);
    end
`ifdef MC_ILLEGAL_TRAP_EN
    if (!is_legal(o)) apply_reset(sel);
`endif
  endtask

  task automatic run_random(input int n);
    logic [6:0] o;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 6))
        0: o = OpLw;
        1: o = OpSw;
        2: o = OpR;
        3: o = OpI;
        4: o = OpJal;
        5: o = OpBeq;
        default: begin
          o = 7'($urandom);
          while (is_legal(o)) o = 7'($urandom);
        end
      endcase
      run_instr($sformatf("rnd%0d_op%b", k, o), o, -1);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    op = OpR;
    zero = 1'b0;
    @(posedge clk);
    #1;
    apply_reset(0);
    run_instr("rtype", OpR, -1);
    zmode = 1;
    run_instr("beq_z1", OpBeq, -1);
    zmode = 2;
    run_instr("beq_z0", OpBeq, -1);
    zmode = 0;
    run_instr("sw", OpSw, -1);
    run_instr("lw", OpLw, -1);
    run_instr("jal", OpJal, -1);
    run_instr("itype", OpI, -1);
    run_instr("illegal", 7'b1111111, -1);
    run_instr("after_ill", OpR, -1);
    run_random(40);

    apply_reset(1);
    run_instr("lw_w3", OpLw, -1);
    // Cycle 8 is the third MEMREAD cycle: abort there, then the next fetch must wait again.
    run_instr("lw_abort", OpLw, 8);
    run_instr("lw_w3_post", OpLw, -1);
    run_instr("illegal_w3", 7'b1111111, -1);
    run_random(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
